store_buffer: RTL and testbench

Circular FIFO of committed stores sitting directly upstream of the data-memory arbiter's store request port. Commit writes retired stores in. The buffer drains them in program order over a valid/ready handshake. The buffer also gives the load path a combinational forwarding lookup, so loads can bypass older stores that have not reached memory yet.

---
 rtl/store_buffer.sv | 191 +++++++++++++++++++
 tb/tb_store_buffer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
//
// Circular FIFO of committed stores placed in front of the data-memory
// arbiter's store request port. Retired stores are written in by commit and
// drained in program order over a valid/ready handshake. A combinational
// forwarding lookup lets loads see data from stores still in the buffer.
//
// Ports:
//   clock, reset              rising-edge clock, async active-high reset
//   enq_valid/enq_ready       commit handshake (enq_ready = ~full)
//   enq_address/value/byte_en store being committed
//   store_request_valid/ready drain handshake towards the arbiter
//   store_request_address/value/byte_en  head entry contents
//   fwd_address               load address probed against buffered stores
//   fwd_hit/fwd_conflict/fwd_value  youngest-match forwarding result
//   count, empty              occupancy
// -----------------------------------------------------------------------------
module store_buffer #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enq_valid,
  output logic                     enq_ready,
  input  logic [XLEN-1:0]          enq_address,
  input  logic [XLEN-1:0]          enq_value,
  input  logic [XLEN/8-1:0]        enq_byte_en,
  output logic                     store_request_valid,
  input  logic                     store_request_ready,
  output logic [XLEN-1:0]          store_request_address,
  output logic [XLEN-1:0]          store_request_value,
  output logic [XLEN/8-1:0]        store_request_byte_en,
  input  logic [XLEN-1:0]          fwd_address,
  output logic                     fwd_hit,
  output logic                     fwd_conflict,
  output logic [XLEN-1:0]          fwd_value,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int IDXW  = $clog2(DEPTH);
  localparam int PW    = IDXW + 1;
  localparam int LANES = XLEN / 8;
  localparam int OFFW  = $clog2(LANES);

  // Pointers carry an extra wrap bit so full and empty stay distinguishable.
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [DEPTH-1:0] valid_q;
  logic [XLEN-1:0]  addr_q [DEPTH];
  logic [XLEN-1:0]  val_q  [DEPTH];
  logic [LANES-1:0] be_q   [DEPTH];

  logic [IDXW-1:0]  head_idx_s;
  logic [IDXW-1:0]  tail_idx_s;
  logic             full_s;
  logic             empty_s;
  logic             enq_fire_s;
  logic             deq_fire_s;

  // Byte-offset bits of the probe address play no part in line matching.
  logic             unused_fwd_offset_s;
  assign unused_fwd_offset_s = ^fwd_address[OFFW-1:0];

  assign head_idx_s = head_q[IDXW-1:0];
  assign tail_idx_s = tail_q[IDXW-1:0];
  assign empty_s    = (head_q == tail_q);
  assign full_s     = (head_idx_s == tail_idx_s) && (head_q[PW-1] != tail_q[PW-1]);

  // Full blocks enqueue even when a dequeue happens in the same cycle.
  assign enq_ready           = ~full_s;
  assign store_request_valid = ~empty_s;
  assign enq_fire_s          = enq_valid && ~full_s;
  assign deq_fire_s          = ~empty_s && store_request_ready;
  assign empty               = empty_s;
  // Pointer difference modulo 2*DEPTH is the occupancy directly.
  assign count               = tail_q - head_q;

  // Next-state pointer arithmetic; wrap falls out of the PW-bit width.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (deq_fire_s) begin
      head_d = head_q + PW'(1);
    end else begin
      head_d = head_q;
    end
    if (enq_fire_s) begin
      tail_d = tail_q + PW'(1);
    end else begin
      tail_d = tail_q;
    end
  end

  // Pointer registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // Entry storage. Enqueue and dequeue never target the same slot in one
  // cycle: that would need the buffer to be both empty and full.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        addr_q[i]  <= '0;
        val_q[i]   <= '0;
        be_q[i]    <= '0;
      end
    end else begin
      if (deq_fire_s) begin
        valid_q[head_idx_s] <= 1'b0;
      end
      if (enq_fire_s) begin
        valid_q[tail_idx_s] <= 1'b1;
        addr_q[tail_idx_s]  <= enq_address;
        val_q[tail_idx_s]   <= enq_value;
        be_q[tail_idx_s]    <= enq_byte_en;
      end
    end
  end

  // Head entry presented to the arbiter; zero while empty so stale
  // contents of drained slots never leak out.
  always_comb begin
    store_request_address = '0;
    store_request_value   = '0;
    store_request_byte_en = '0;
    if (!empty_s) begin
      store_request_address = addr_q[head_idx_s];
      store_request_value   = val_q[head_idx_s];
      store_request_byte_en = be_q[head_idx_s];
    end else begin
      store_request_address = '0;
      store_request_value   = '0;
      store_request_byte_en = '0;
    end
  end

  logic             match_found_s;
  logic [XLEN-1:0]  match_val_s;
  logic [LANES-1:0] match_be_s;
  logic [IDXW-1:0]  slot_s;

  // Forwarding search: walk from oldest (head) to youngest; later matches
  // overwrite earlier ones, so the survivor is the youngest match. Only
  // registered entries take part, so a same-cycle enqueue is invisible.
  always_comb begin
    match_found_s = 1'b0;
    match_val_s   = '0;
    match_be_s    = '0;
    slot_s        = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot_s = head_idx_s + IDXW'(k);
      if (valid_q[slot_s] &&
          (addr_q[slot_s][XLEN-1:OFFW] == fwd_address[XLEN-1:OFFW]) &&
          (be_q[slot_s] != '0)) begin
        match_found_s = 1'b1;
        match_val_s   = val_q[slot_s];
        match_be_s    = be_q[slot_s];
      end else begin
        match_found_s = match_found_s;
      end
    end
  end

  // Full-coverage match forwards; a partial youngest match forces a wait.
  always_comb begin
    fwd_hit      = 1'b0;
    fwd_conflict = 1'b0;
    fwd_value    = '0;
    if (match_found_s) begin
      fwd_hit      = (match_be_s == '1);
      fwd_conflict = (match_be_s != '1);
      fwd_value    = match_val_s;
    end else begin
      fwd_hit      = 1'b0;
      fwd_conflict = 1'b0;
      fwd_value    = '0;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

  localparam int XLEN  = 64;
  localparam int DEPTH = 8;

  logic              clock = 1'b0;
  logic              reset;
  logic              enq_valid;
  logic              enq_ready;
  logic [XLEN-1:0]   enq_address;
  logic [XLEN-1:0]   enq_value;
  logic [7:0]        enq_byte_en;
  logic              store_request_valid;
  logic              store_request_ready;
  logic [XLEN-1:0]   store_request_address;
  logic [XLEN-1:0]   store_request_value;
  logic [7:0]        store_request_byte_en;
  logic [XLEN-1:0]   fwd_address;
  logic              fwd_hit;
  logic              fwd_conflict;
  logic [XLEN-1:0]   fwd_value;
  logic [3:0]        count;
  logic              empty;

  store_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .enq_valid             (enq_valid),
    .enq_ready             (enq_ready),
    .enq_address           (enq_address),
    .enq_value             (enq_value),
    .enq_byte_en           (enq_byte_en),
    .store_request_valid   (store_request_valid),
    .store_request_ready   (store_request_ready),
    .store_request_address (store_request_address),
    .store_request_value   (store_request_value),
    .store_request_byte_en (store_request_byte_en),
    .fwd_address           (fwd_address),
    .fwd_hit               (fwd_hit),
    .fwd_conflict          (fwd_conflict),
    .fwd_value             (fwd_value),
    .count                 (count),
    .empty                 (empty)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] a;
    logic [63:0] v;
    logic [7:0]  be;
  } ent_t;

  ent_t model_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Compare every observable output with the queue model.
  task automatic check_all();
    logic        m_hit;
    logic        m_conf;
    logic [63:0] m_val;
    logic        found;
    m_hit = 1'b0; m_conf = 1'b0; m_val = 64'd0; found = 1'b0;
    for (int i = model_q.size() - 1; i >= 0; i--) begin
      if (!found && ((model_q[i].a >> 3) == (fwd_address >> 3)) && (model_q[i].be != 8'h00)) begin
        found  = 1'b1;
        m_hit  = (model_q[i].be == 8'hFF);
        m_conf = (model_q[i].be != 8'hFF);
        m_val  = model_q[i].v;
      end
    end
    check_eq("count", 64'(count), 64'(model_q.size()));
    check_eq("empty", 64'(empty), 64'(model_q.size() == 0));
    check_eq("enq_ready", 64'(enq_ready), 64'(model_q.size() < DEPTH));
    check_eq("sr_valid", 64'(store_request_valid), 64'(model_q.size() != 0));
    if (model_q.size() != 0) begin
      check_eq("sr_addr", store_request_address, model_q[0].a);
      check_eq("sr_value", store_request_value, model_q[0].v);
      check_eq("sr_be", 64'(store_request_byte_en), 64'(model_q[0].be));
    end else begin
      check_eq("sr_addr_idle", store_request_address, 64'd0);
    end
    check_eq("fwd_hit", 64'(fwd_hit), 64'(m_hit));
    check_eq("fwd_conflict", 64'(fwd_conflict), 64'(m_conf));
    check_eq("fwd_value", fwd_value, m_val);
  endtask

  // One clock: check at negedge, then advance the model on the edge.
  task automatic cycle();
    logic do_enq;
    logic do_deq;
    ent_t e;
    @(negedge clock);
    check_all();
    @(posedge clock);
    do_enq = enq_valid && (model_q.size() < DEPTH);
    do_deq = store_request_ready && (model_q.size() != 0);
    e.a = enq_address; e.v = enq_value; e.be = enq_byte_en;
    if (do_deq) void'(model_q.pop_front());
    if (do_enq) model_q.push_back(e);
    #1;
  endtask

  task automatic set_enq(input logic [63:0] a, input logic [63:0] v, input logic [7:0] be);
    enq_valid   = 1'b1;
    enq_address = a;
    enq_value   = v;
    enq_byte_en = be;
  endtask

  initial begin
    reset = 1'b1;
    enq_valid = 1'b0; enq_address = 64'd0; enq_value = 64'd0; enq_byte_en = 8'h00;
    store_request_ready = 1'b0; fwd_address = 64'd0;
    #1;
    check_eq("rst_count", 64'(count), 64'd0);
    check_eq("rst_empty", 64'(empty), 64'd1);
    check_eq("rst_enq_ready", 64'(enq_ready), 64'd1);
    check_eq("rst_sr_valid", 64'(store_request_valid), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Ordering with backpressure.
    for (int i = 0; i < 3; i++) begin
      set_enq(64'h100 + 64'(i) * 64'd8, 64'hA0 + 64'(i), 8'hFF);
      cycle();
    end
    enq_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq("hold_addr", store_request_address, 64'h100);
      cycle();
    end
    store_request_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_eq("drain_addr", store_request_address, 64'h100 + 64'(i) * 64'd8);
      cycle();
    end
    check_eq("drained_empty", 64'(empty), 64'd1);

    // Full boundary.
    store_request_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      set_enq(64'h400 + 64'(i) * 64'd8, {$urandom, $urandom}, 8'hFF);
      cycle();
    end
    enq_valid = 1'b0;
    check_eq("full_count", 64'(count), 64'd8);
    check_eq("full_enq_ready", 64'(enq_ready), 64'd0);
    set_enq(64'h800, 64'h77, 8'hFF);
    store_request_ready = 1'b1;
    cycle();
    enq_valid = 1'b0;
    check_eq("after_full_count", 64'(count), 64'd7);
    check_eq("after_full_enq_ready", 64'(enq_ready), 64'd1);
    for (int i = 0; i < 8; i++) cycle();

    // Forwarding: youngest partial match, then youngest full match.
    store_request_ready = 1'b0;
    set_enq(64'h200, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF); cycle();
    set_enq(64'h204, 64'h1234, 8'h0F); cycle();
    enq_valid = 1'b0;
    fwd_address = 64'h200;
    #1;
    check_eq("fwd1_conflict", 64'(fwd_conflict), 64'd1);
    check_eq("fwd1_hit", 64'(fwd_hit), 64'd0);
    check_eq("fwd1_value", fwd_value, 64'h1234);
    set_enq(64'h200, 64'h5555_5555_5555_5555, 8'hFF); cycle();
    enq_valid = 1'b0;
    check_eq("fwd2_hit", 64'(fwd_hit), 64'd1);
    check_eq("fwd2_conflict", 64'(fwd_conflict), 64'd0);
    check_eq("fwd2_value", fwd_value, 64'h5555_5555_5555_5555);
    store_request_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();

    // Same-cycle enqueue is not visible to forwarding.
    store_request_ready = 1'b0;
    fwd_address = 64'h300;
    set_enq(64'h300, 64'hDEAD_BEEF, 8'hFF);
    #1;
    check_eq("same_cycle_hit", 64'(fwd_hit), 64'd0);
    cycle();
    enq_valid = 1'b0;
    check_eq("next_cycle_hit", 64'(fwd_hit), 64'd1);
    check_eq("next_cycle_value", fwd_value, 64'hDEAD_BEEF);
    store_request_ready = 1'b1;
    cycle(); cycle();

    // Random streaming with wrap-around and colliding lines.
    for (int i = 0; i < 80; i++) begin
      enq_valid           = ($urandom_range(0, 3) != 0);
      enq_address         = 64'h1000 + 64'($urandom_range(0, 5)) * 64'd4;
      enq_value           = {$urandom, $urandom};
      enq_byte_en         = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
      store_request_ready = ($urandom_range(0, 1) != 0);
      fwd_address         = 64'h1000 + 64'($urandom_range(0, 5)) * 64'd4;
      cycle();
      check_eq("count_bound", 64'(count <= 4'd8), 64'd1);
    end
    enq_valid = 1'b0;
    store_request_ready = 1'b1;
    for (int i = 0; i < 9; i++) cycle();

    // Asynchronous reset with three entries held.
    store_request_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_enq(64'h600 + 64'(i) * 64'd8, 64'h60 + 64'(i), 8'hFF);
      cycle();
    end
    enq_valid = 1'b0;
    fwd_address = 64'h600;
    #2;
    reset = 1'b1;
    #1;
    model_q.delete();
    check_eq("arst_empty", 64'(empty), 64'd1);
    check_eq("arst_count", 64'(count), 64'd0);
    check_eq("arst_sr_valid", 64'(store_request_valid), 64'd0);
    check_eq("arst_enq_ready", 64'(enq_ready), 64'd1);
    check_eq("arst_fwd_hit", 64'(fwd_hit), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    store_request_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_eq("post_rst_sr_valid", 64'(store_request_valid), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
